// File: rtl/dfx_data_xmit_if.sv
// rtl/dfx_data_xmit_if.sv - DFX word input and link flit output handshake bundle
interface dfx_data_xmit_if #(
  parameter int DATA_W = 1034,
  parameter int FLIT_W = 64
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              tx_valid;
  logic [FLIT_W-1:0] tx_flit;
  logic              tx_head;
  logic              tx_tail;
  logic              tx_ready;

  modport master (
    output in_valid, in_data, tx_ready,
    input  in_ready, tx_valid, tx_flit, tx_head, tx_tail
  );

  modport slave (
    input  in_valid, in_data, tx_ready,
    output in_ready, tx_valid, tx_flit, tx_head, tx_tail
  );
endinterface

// File: rtl/dfx_data_xmit.sv
// rtl/dfx_data_xmit.sv - DFX word FIFO and LSB-first flit serializer toward the link
// Optional even parity output on tx_parity when DFX_TX_PARITY_EN is defined.
module dfx_data_xmit #(
  parameter int DATA_W = 1034,
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dfx_data_xmit_if.slave dfx,
  output logic         tx_busy,
`ifdef DFX_TX_PARITY_EN
  output logic         tx_parity,
`endif
  output logic [15:0]  pkt_cnt
);
  localparam int NFLIT = (DATA_W + FLIT_W - 1) / FLIT_W;
  localparam int SH_W  = NFLIT * FLIT_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int FCW   = (NFLIT > 1) ? $clog2(NFLIT) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  state_t            state;
  logic [FCW-1:0]    flit_cnt;
  logic [SH_W-1:0]   shreg;
  logic              tx_valid_q, tx_head_q, tx_tail_q;
  logic              in_ready_w, push, pop, tail_acc;

  // in_ready looks only at the registered count, so a full FIFO rejects even on a pop edge
  assign in_ready_w = (count != (AW+1)'(DEPTH));
  assign push       = dfx.in_valid && in_ready_w;
  assign tail_acc   = (state == SEND) && dfx.tx_ready && tx_tail_q;
  assign pop        = (count != '0) && ((state == IDLE) || tail_acc);

  assign dfx.in_ready = in_ready_w;
  assign dfx.tx_valid = tx_valid_q;
  assign dfx.tx_flit  = shreg[FLIT_W-1:0];
  assign dfx.tx_head  = tx_head_q;
  assign dfx.tx_tail  = tx_tail_q;
  assign tx_busy      = (state != IDLE) || (count != '0);

`ifdef DFX_TX_PARITY_EN
  // shreg is zero whenever no flit is presented, so parity reads 0 then
  assign tx_parity = ^shreg[FLIT_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dfx.in_data;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      flit_cnt   <= '0;
      shreg      <= '0;
      pkt_cnt    <= '0;
      tx_valid_q <= 1'b0;
      tx_head_q  <= 1'b0;
      tx_tail_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (tail_acc) pkt_cnt <= pkt_cnt + 1'b1;

      // pop only occurs from IDLE or on a tail accept, so it always starts a fresh word
      if (pop) begin
        shreg      <= SH_W'(mem[rd_ptr]);
        flit_cnt   <= '0;
        state      <= SEND;
        tx_valid_q <= 1'b1;
        tx_head_q  <= 1'b1;
        tx_tail_q  <= (NFLIT == 1);
      end else if (state == SEND && dfx.tx_ready) begin
        shreg     <= shreg >> FLIT_W;
        tx_head_q <= 1'b0;
        if (tx_tail_q) begin
          state      <= IDLE;
          flit_cnt   <= '0;
          tx_valid_q <= 1'b0;
          tx_tail_q  <= 1'b0;
        end else begin
          flit_cnt  <= flit_cnt + 1'b1;
          tx_tail_q <= (flit_cnt == FCW'(NFLIT - 2));
        end
      end
    end
  end
endmodule

// File: tb/tb_dfx_data_xmit.sv
// tb/tb_dfx_data_xmit.sv - directed self-checking bench for dfx_data_xmit
module tb_dfx_data_xmit;
  localparam int DATA_W = 1034;
  localparam int FLIT_W = 64;
  localparam int NFLIT  = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_busy;
  logic [15:0] pkt_cnt;
`ifdef DFX_TX_PARITY_EN
  logic        tx_parity;
`endif
  int n_cmp = 0;
  int n_mis = 0;

  dfx_data_xmit_if #(.DATA_W(DATA_W), .FLIT_W(FLIT_W)) xif ();

  dfx_data_xmit #(.DATA_W(DATA_W), .FLIT_W(FLIT_W), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dfx      (xif.slave),
    .tx_busy  (tx_busy),
`ifdef DFX_TX_PARITY_EN
    .tx_parity(tx_parity),
`endif
    .pkt_cnt  (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    int wt;
    xif.in_valid = 1'b1;
    xif.in_data  = w;
    wt = 0;
    while (!xif.in_ready && wt < 200) begin
      @(negedge clk);
      wt++;
    end
    check("push_timeout", 64'(wt < 200), 64'd1);
    @(negedge clk);
    xif.in_valid = 1'b0;
  endtask

  task automatic rx_word(input logic [DATA_W-1:0] w, input int stall_at, input bit strict,
                         input bit chk_full, input int stop_at);
    logic [NFLIT*FLIT_W-1:0] pad;
    logic [FLIT_W-1:0]       ef;
    int                      wt;
    pad = {54'b0, w};
    for (int i = 0; i < NFLIT; i++) begin
      ef = pad[FLIT_W*i +: FLIT_W];
      xif.tx_ready = 1'b1;
      if (!strict) begin
        wt = 0;
        while (!xif.tx_valid && wt < 100) begin
          @(negedge clk);
          wt++;
        end
      end
      check("tx_valid", 64'(xif.tx_valid), 64'd1);
      if (i == stop_at) begin
        xif.tx_ready = 1'b0;
        return;
      end
      check("tx_flit", xif.tx_flit, ef);
      check("tx_head", 64'(xif.tx_head), 64'(i == 0));
      check("tx_tail", 64'(xif.tx_tail), 64'(i == NFLIT - 1));
`ifdef DFX_TX_PARITY_EN
      check("tx_parity", 64'(tx_parity), 64'(^ef));
`endif
      if (chk_full && i == NFLIT - 1) check("full_at_tail", 64'(xif.in_ready), 64'd0);
      if (i == stall_at) begin
        xif.tx_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", 64'(xif.tx_valid), 64'd1);
          check("stall_flit", xif.tx_flit, ef);
          check("stall_head", 64'(xif.tx_head), 64'(i == 0));
          check("stall_tail", 64'(xif.tx_tail), 64'(i == NFLIT - 1));
        end
        xif.tx_ready = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] w1, w2, wx;
    logic [DATA_W-1:0] wb [5];

    w1 = '0;
    w1[0] = 1'b1;
    w1[1033:1024] = 10'h3FF;
    w2 = '0;
    for (int i = 0; i < 16; i++) w2[64*i +: 64] = 64'hDEAD_BEEF_0000_0000 | 64'(i);
    w2[63:0]      = 64'h3;
    w2[127:64]    = 64'h7;
    w2[1033:1024] = 10'h2B5;
    for (int k = 0; k < 5; k++) begin
      wb[k] = '0;
      for (int i = 0; i < 16; i++) wb[k][64*i +: 64] = {32'hC0DE_0000 | 32'(k), 32'(i)};
      wb[k][1033:1024] = 10'(k + 1);
    end
    wx = '1;

    rst_n = 1'b1;
    xif.in_valid = 1'b0;
    xif.in_data  = '0;
    xif.tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(xif.in_ready), 64'd1);
    check("rst_tx_valid", 64'(xif.tx_valid), 64'd0);
    check("rst_tx_flit", xif.tx_flit, 64'd0);
    check("rst_tx_head", 64'(xif.tx_head), 64'd0);
    check("rst_tx_tail", 64'(xif.tx_tail), 64'd0);
    check("rst_tx_busy", 64'(tx_busy), 64'd0);
    check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
`ifdef DFX_TX_PARITY_EN
    check("rst_parity", 64'(tx_parity), 64'd0);
`endif
    rst_n = 1'b0;
    @(negedge clk);

    // single word, latency and flit order
    push_word(w1);
    check("lat_idle", 64'(xif.tx_valid), 64'd0);
    check("lat_busy", 64'(tx_busy), 64'd1);
    @(negedge clk);
    check("lat_head", 64'(xif.tx_valid), 64'd1);
    check("w1_flit0", xif.tx_flit, 64'h1);
    rx_word(w1, -1, 1'b1, 1'b0, NFLIT);
    check("w1_idle_valid", 64'(xif.tx_valid), 64'd0);
    check("w1_idle_flit", xif.tx_flit, 64'd0);
    check("w1_busy", 64'(tx_busy), 64'd0);
    check("w1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // stall at flit 3; flit0=0x3 and flit1=0x7 exercise parity
    push_word(w2);
    rx_word(w2, 3, 1'b0, 1'b0, NFLIT);
    check("w2_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // fill FIFO behind a stalled word, then drain with no bubbles
    xif.tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_word(wb[k]);
    check("b2b_full", 64'(xif.in_ready), 64'd0);
    check("b2b_head_hold", 64'(xif.tx_head), 64'd1);
    xif.in_valid = 1'b1;
    xif.in_data  = wx;
    rx_word(wb[0], -1, 1'b1, 1'b1, NFLIT);
    xif.in_valid = 1'b0;
    for (int k = 1; k < 5; k++) rx_word(wb[k], -1, 1'b1, 1'b0, NFLIT);
    check("b2b_end_valid", 64'(xif.tx_valid), 64'd0);
    check("b2b_rejected", 64'(tx_busy), 64'd0);
    check("b2b_pkt_cnt", 64'(pkt_cnt), 64'd7);

    // reset in the middle of a word
    push_word(w2);
    rx_word(w2, -1, 1'b0, 1'b0, 8);
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", 64'(xif.tx_valid), 64'd0);
    check("mid_rst_pkt", 64'(pkt_cnt), 64'd0);
    check("mid_rst_busy", 64'(tx_busy), 64'd0);
    check("mid_rst_flit", xif.tx_flit, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    xif.tx_ready = 1'b1;
    @(negedge clk);
    push_word(w1);
    rx_word(w1, -1, 1'b0, 1'b0, NFLIT);
    check("post_rst_pkt", 64'(pkt_cnt), 64'd1);
    check("post_rst_busy", 64'(tx_busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
